sc_neuron_integrator: RTL and testbench



---
 rtl/neuron_pkg.sv | 15 +
 rtl/sc_refract_counter.sv | 38 +++
 rtl/sc_neuron_integrator.sv | 164 ++++++++++++++++
 tb/tb_sc_neuron_integrator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the integrate-and-fire neuron: FSM state encodings
// (also decoded by the debug monitor) and the saturating-add guard width.
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_ACCUM   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_REFRACT = 3'd3
    } neuron_state_e;

    // Extra carry bit kept above the data width so overflow can be detected.
    localparam int SAT_ADD_GUARD_BITS = 1;

endpackage

// File: rtl/sc_refract_counter.sv
// Loadable down-counter; done_o flags the final step (count == 1), idle_o flags zero.
// Used for the refractory period and, with NEURON_LEAK_EN, for the leak timer.
module sc_refract_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o,
    output logic             idle_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign idle_o = (cnt_q == '0);

endmodule

// File: rtl/sc_neuron_integrator.sv
// Integrate-and-fire controller feeding an external unsigned ">" comparator.
// Optional membrane leak is enabled by defining NEURON_LEAK_EN.
module sc_neuron_integrator
    import neuron_pkg::*;
#(
    parameter int                          NUMBER_DATAWIDTH = 8,
    parameter int                          REFRACT_CYCLES   = 4,
    parameter logic [NUMBER_DATAWIDTH-1:0] THRESHOLD_RESET  = 8'd100,
    parameter int                          LEAK_PERIOD      = 16,
    parameter int                          LEAK_SHIFT       = 3
) (
    input  logic                        SC_NEURONINT_CLOCK_50,
    input  logic                        SC_NEURONINT_RESET_InHigh,
    input  logic                        SC_NEURONINT_inValid_In,
    output logic                        SC_NEURONINT_inReady_Out,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_NEURONINT_inData_InBUS,
    input  logic                        SC_NEURONINT_thrLoad_In,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_NEURONINT_thr_InBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_NEURONINT_potential_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_NEURONINT_threshold_OutBUS,
    input  logic                        SC_NEURONINT_cmpResult_In,
    output logic                        SC_NEURONINT_spike_Out,
    output logic [2:0]                  SC_NEURONINT_state_OutBUS
);

    localparam int W      = NUMBER_DATAWIDTH;
    localparam int SUM_W  = W + SAT_ADD_GUARD_BITS;
    localparam int REFR_W = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);
    localparam logic [REFR_W-1:0] REFR_LOAD = REFR_W'(REFRACT_CYCLES);

    logic            clk;
    logic            rst;
    neuron_state_e   state_q, state_d;
    logic [W-1:0]    potential_q, potential_d;
    logic [W-1:0]    threshold_q, threshold_d;
    logic            spike_q, spike_d;
    logic            accept;
    logic [SUM_W-1:0] sum_w;
    logic [W-1:0]    sat_sum;
    logic            refr_load, refr_done, refr_idle;
    logic            leak_fire;
    logic [W-1:0]    leak_value;

    assign clk = SC_NEURONINT_CLOCK_50;
    assign rst = SC_NEURONINT_RESET_InHigh;

    // Handshake: a sample transfers on a rising edge where inValid and inReady
    // are both high; inReady is high only in ACCUM and never during reset.
    assign SC_NEURONINT_inReady_Out = (state_q == ST_ACCUM) && !rst;
    assign accept = SC_NEURONINT_inValid_In && SC_NEURONINT_inReady_Out;

    assign sum_w   = SUM_W'(potential_q) + SUM_W'(SC_NEURONINT_inData_InBUS);
    assign sat_sum = sum_w[SUM_W-1] ? '1 : sum_w[W-1:0];

    sc_refract_counter #(.CNT_W(REFR_W)) u_refract (
        .clk        (clk),
        .rst        (rst),
        .load_i     (refr_load),
        .load_val_i (REFR_LOAD),
        .dec_i      (state_q == ST_REFRACT),
        .done_o     (refr_done),
        .idle_o     (refr_idle)
    );

`ifdef NEURON_LEAK_EN
    localparam int LEAK_W = (LEAK_PERIOD < 2) ? 1 : $clog2(LEAK_PERIOD + 1);

    logic              leak_load, leak_dec, leak_done, leak_idle;
    logic [LEAK_W-1:0] leak_val;

    // The timer starts from zero, so the first idle cycle loads PERIOD-1 and
    // the leak lands on the edge closing the PERIOD-th idle cycle.
    assign leak_fire  = (state_q == ST_ACCUM) && !accept && (leak_done || (LEAK_PERIOD == 1));
    assign leak_value = potential_q - (potential_q >> LEAK_SHIFT);

    always_comb begin
        leak_load = 1'b1;
        leak_val  = '0;
        leak_dec  = 1'b0;
        if ((state_q == ST_ACCUM) && !accept && !leak_fire) begin
            if (leak_idle) begin
                leak_val = LEAK_W'(LEAK_PERIOD - 1);
            end else begin
                leak_load = 1'b0;
                leak_dec  = 1'b1;
            end
        end
    end

    sc_refract_counter #(.CNT_W(LEAK_W)) u_leak (
        .clk        (clk),
        .rst        (rst),
        .load_i     (leak_load),
        .load_val_i (leak_val),
        .dec_i      (leak_dec),
        .done_o     (leak_done),
        .idle_o     (leak_idle)
    );
`else
    assign leak_fire  = 1'b0;
    assign leak_value = potential_q;
`endif

    always_comb begin
        state_d     = state_q;
        potential_d = potential_q;
        threshold_d = SC_NEURONINT_thrLoad_In ? SC_NEURONINT_thr_InBUS : threshold_q;
        spike_d     = 1'b0;
        refr_load   = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    potential_d = sat_sum;
                    state_d     = ST_CHECK;
                end else if (leak_fire) begin
                    potential_d = leak_value;
                end
            end
            ST_CHECK: begin
                if (SC_NEURONINT_cmpResult_In) begin
                    state_d = ST_FIRE;
                    spike_d = 1'b1;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_FIRE: begin
                potential_d = '0;
                if (REFRACT_CYCLES == 0) begin
                    state_d = ST_ACCUM;
                end else begin
                    refr_load = 1'b1;
                    state_d   = ST_REFRACT;
                end
            end
            ST_REFRACT: begin
                if (refr_done || refr_idle) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            potential_q <= '0;
            threshold_q <= THRESHOLD_RESET;
            spike_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            potential_q <= potential_d;
            threshold_q <= threshold_d;
            spike_q     <= spike_d;
        end
    end

    assign SC_NEURONINT_potential_OutBUS = potential_q;
    assign SC_NEURONINT_threshold_OutBUS = threshold_q;
    assign SC_NEURONINT_spike_Out        = spike_q;
    assign SC_NEURONINT_state_OutBUS     = state_q;

endmodule

// File: tb/tb_sc_neuron_integrator.sv
// Directed bench for sc_neuron_integrator with a behavioural ">" comparator.
// Leak checks are compiled in only when NEURON_LEAK_EN is defined.
module tb_sc_neuron_integrator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       thr_load;
    logic [7:0] thr_in;
    logic [7:0] pot_out;
    logic [7:0] thr_out;
    logic       cmp;
    logic       spike;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    sc_neuron_integrator dut (
        .SC_NEURONINT_CLOCK_50         (clk),
        .SC_NEURONINT_RESET_InHigh     (rst),
        .SC_NEURONINT_inValid_In       (in_valid),
        .SC_NEURONINT_inReady_Out      (in_ready),
        .SC_NEURONINT_inData_InBUS     (in_data),
        .SC_NEURONINT_thrLoad_In       (thr_load),
        .SC_NEURONINT_thr_InBUS        (thr_in),
        .SC_NEURONINT_potential_OutBUS (pot_out),
        .SC_NEURONINT_threshold_OutBUS (thr_out),
        .SC_NEURONINT_cmpResult_In     (cmp),
        .SC_NEURONINT_spike_Out        (spike),
        .SC_NEURONINT_state_OutBUS     (state)
    );

    // External comparator: c0 = potential, c1 = threshold
    assign cmp = (pot_out > thr_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        thr_load = 1'b0;
        thr_in   = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic drive_sample(input logic [7:0] d, output bit ok);
        int n;
        wait_ready(n);
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            in_data  = d;
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic load_thr(input logic [7:0] t);
        thr_load = 1'b1;
        thr_in   = t;
        tick();
        thr_load = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        thr_load = 1'b0;
        thr_in   = '0;
        #3;
        total++; if (pot_out !== 8'd0) begin bad++; $display("FAIL reset_pot got=%0d exp=0", pot_out); end
        total++; if (thr_out !== 8'd100) begin bad++; $display("FAIL reset_thr got=%0d exp=100", thr_out); end
        total++; if (spike !== 1'b0) begin bad++; $display("FAIL reset_spike got=%0b exp=0", spike); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", in_ready); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL release_state got=%0d exp=0", state); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_accumulate;
        bit ok;
        int n;
        logic [7:0] samp [6] = '{8'd40, 8'd40, 8'd30, 8'd40, 8'd40, 8'd21};
        logic [7:0] exp_p [6] = '{8'd40, 8'd80, 8'd110, 8'd40, 8'd80, 8'd101};
        bit         fire  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_sample(samp[i], ok);
            total++; if (!ok) begin bad++; $display("FAIL acc_accept[%0d] got=not_ready exp=ready", i); end
            total++; if (state !== 3'd1) begin bad++; $display("FAIL acc_check_state[%0d] got=%0d exp=1", i, state); end
            total++; if (pot_out !== exp_p[i]) begin bad++; $display("FAIL acc_pot[%0d] got=%0d exp=%0d", i, pot_out, exp_p[i]); end
            tick();
            total++; if (spike !== fire[i]) begin bad++; $display("FAIL acc_spike[%0d] got=%0b exp=%0b", i, spike, fire[i]); end
            if (fire[i]) begin
                total++; if (state !== 3'd2) begin bad++; $display("FAIL acc_fire_state[%0d] got=%0d exp=2", i, state); end
                tick();
                total++; if (spike !== 1'b0) begin bad++; $display("FAIL acc_spike_width[%0d] got=%0b exp=0", i, spike); end
                total++; if (state !== 3'd3) begin bad++; $display("FAIL acc_refract_state[%0d] got=%0d exp=3", i, state); end
                wait_ready(n);
                total++; if (n !== 4) begin bad++; $display("FAIL acc_refract_len[%0d] got=%0d exp=4", i, n); end
                total++; if (pot_out !== 8'd0) begin bad++; $display("FAIL acc_pot_clear[%0d] got=%0d exp=0", i, pot_out); end
            end else begin
                total++; if (state !== 3'd0) begin bad++; $display("FAIL acc_back_state[%0d] got=%0d exp=0", i, state); end
            end
        end
    endtask

    task automatic test_saturation;
        bit ok;
        int n;
        do_reset();
        load_thr(8'd250);
        total++; if (thr_out !== 8'd250) begin bad++; $display("FAIL sat_thr_load got=%0d exp=250", thr_out); end
        drive_sample(8'd200, ok);
        tick();
        total++; if (spike !== 1'b0) begin bad++; $display("FAIL sat_first_spike got=%0b exp=0", spike); end
        drive_sample(8'd200, ok);
        total++; if (pot_out !== 8'd255) begin bad++; $display("FAIL sat_pot got=%0d exp=255", pot_out); end
        tick();
        total++; if (spike !== 1'b1) begin bad++; $display("FAIL sat_spike got=%0b exp=1", spike); end
        wait_ready(n);
        load_thr(8'd255);
        for (int i = 0; i < 2; i++) begin
            drive_sample(8'd255, ok);
            total++; if (pot_out !== 8'd255) begin bad++; $display("FAIL sat_max_pot[%0d] got=%0d exp=255", i, pot_out); end
            tick();
            total++; if (spike !== 1'b0) begin bad++; $display("FAIL sat_max_nofire[%0d] got=%0b exp=0", i, spike); end
            total++; if (state !== 3'd0) begin bad++; $display("FAIL sat_max_state[%0d] got=%0d exp=0", i, state); end
        end
    endtask

    task automatic test_threshold_edge;
        bit ok;
        int n;
        do_reset();
        drive_sample(8'd50, ok);
        tick();
        drive_sample(8'd50, ok);
        total++; if (pot_out !== 8'd100) begin bad++; $display("FAIL edge_pot got=%0d exp=100", pot_out); end
        tick();
        total++; if (spike !== 1'b0) begin bad++; $display("FAIL edge_equal_nofire got=%0b exp=0", spike); end
        load_thr(8'd99);
        drive_sample(8'd0, ok);
        total++; if (pot_out !== 8'd100) begin bad++; $display("FAIL edge_zero_pot got=%0d exp=100", pot_out); end
        tick();
        total++; if (spike !== 1'b1) begin bad++; $display("FAIL edge_lowered_fire got=%0b exp=1", spike); end
        wait_ready(n);
        load_thr(8'd200);
        drive_sample(8'd100, ok);
        thr_load = 1'b1;
        thr_in   = 8'd50;
        tick();
        thr_load = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL edge_load_in_check_state got=%0d exp=0", state); end
        total++; if (thr_out !== 8'd50) begin bad++; $display("FAIL edge_load_in_check_thr got=%0d exp=50", thr_out); end
        drive_sample(8'd0, ok);
        tick();
        total++; if (spike !== 1'b1) begin bad++; $display("FAIL edge_next_check_fire got=%0b exp=1", spike); end
        wait_ready(n);
    endtask

    task automatic test_back_to_back;
        int acc;
        int n;
        do_reset();
        acc      = 0;
        in_valid = 1'b1;
        in_data  = 8'd1;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) acc++;
            tick();
        end
        total++; if (acc !== 6) begin bad++; $display("FAIL b2b_accepts got=%0d exp=6", acc); end
        total++; if (pot_out !== 8'd6) begin bad++; $display("FAIL b2b_pot got=%0d exp=6", pot_out); end
        thr_load = 1'b1;
        thr_in   = 8'd5;
        tick();
        thr_load = 1'b0;
        total++; if (pot_out !== 8'd7) begin bad++; $display("FAIL b2b_pot_fire got=%0d exp=7", pot_out); end
        tick();
        total++; if (spike !== 1'b1) begin bad++; $display("FAIL b2b_spike got=%0b exp=1", spike); end
        wait_ready(n);
        total++; if (n !== 5) begin bad++; $display("FAIL b2b_blocked_cycles got=%0d exp=5", n); end
        total++; if (pot_out !== 8'd0) begin bad++; $display("FAIL b2b_not_consumed got=%0d exp=0", pot_out); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_refract;
        bit ok;
        do_reset();
        load_thr(8'd10);
        drive_sample(8'd20, ok);
        tick();
        tick();
        tick();
        tick();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL rr_in_refract got=%0d exp=3", state); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rr_async_state got=%0d exp=0", state); end
        total++; if (thr_out !== 8'd100) begin bad++; $display("FAIL rr_async_thr got=%0d exp=100", thr_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rr_async_ready got=%0b exp=0", in_ready); end
        total++; if (pot_out !== 8'd0 || spike !== 1'b0) begin bad++; $display("FAIL rr_async_pot_spike got=%0d/%0b exp=0/0", pot_out, spike); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_release_ready got=%0b exp=1", in_ready); end
        drive_sample(8'd40, ok);
        total++; if (pot_out !== 8'd40) begin bad++; $display("FAIL rr_after_pot got=%0d exp=40", pot_out); end
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rr_after_state got=%0d exp=0", state); end
    endtask

`ifdef NEURON_LEAK_EN
    task automatic test_leak;
        bit ok;
        do_reset();
        load_thr(8'd200);
        drive_sample(8'd80, ok);
        tick();
        for (int i = 0; i < 15; i++) tick();
        total++; if (pot_out !== 8'd80) begin bad++; $display("FAIL leak_early got=%0d exp=80", pot_out); end
        tick();
        total++; if (pot_out !== 8'd70) begin bad++; $display("FAIL leak_step got=%0d exp=70", pot_out); end
        for (int i = 0; i < 14; i++) tick();
        drive_sample(8'd0, ok);
        total++; if (pot_out !== 8'd70) begin bad++; $display("FAIL leak_sample_blocks got=%0d exp=70", pot_out); end
        tick();
        for (int i = 0; i < 15; i++) tick();
        total++; if (pot_out !== 8'd70) begin bad++; $display("FAIL leak_restart got=%0d exp=70", pot_out); end
        tick();
        total++; if (pot_out !== 8'd62) begin bad++; $display("FAIL leak_second got=%0d exp=62", pot_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_accumulate();
        test_saturation();
        test_threshold_edge();
        test_back_to_back();
        test_reset_refract();
`ifdef NEURON_LEAK_EN
        test_leak();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
